// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-controller signal bundle: ID/EX hazard inputs in, pipeline stall/flush enables and counters out.
// The master side drives the hazard fields; the slave side is the controller.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       idex_rd;
    logic             idex_memread;
    logic             ex_branch_tkn;
    logic             dmem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cycles;
    logic [15:0]      flush_count;

    // No handshake: every input is a level that is valid for the whole cycle it is presented.
    // The controls are combinational responses in the same cycle; the counters update on the clock edge.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_rd, idex_memread,
               ex_branch_tkn, dmem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, idex_rd, idex_memread,
               ex_branch_tkn, dmem_busy,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, data-memory freeze, and taken-branch flush,
// with wrapping stall/flush performance counters.
module hazard_stall_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  hz,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] LD_CNT_INIT = 3'(LOAD_LAT - 1);

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q;
    logic [15:0]      flush_q;

    logic load_use;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;

    // x0 is never written, so a load targeting it can never create a dependency.
    assign load_use = hz.idex_memread && (hz.idex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.idex_rd == hz.id_rs1)) ||
                       (hz.id_use_rs2 && (hz.idex_rd == hz.id_rs2)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (hz.dmem_busy) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_freeze = 1'b1;
                    state_d     = ST_MEM_WAIT;
                end else if (hz.ex_branch_tkn) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = ST_RUN;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = ST_LD_STALL;
                        cnt_d   = LD_CNT_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LD_STALL: begin
                if (hz.dmem_busy) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    pipe_freeze = 1'b1;
                end else if (hz.ex_branch_tkn) begin
                    // A taken branch squashes the stalled consumer, so the remaining bubbles are moot.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = ST_RUN;
                    cnt_d       = 3'd0;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
        if (rst) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            pipe_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_write)  stall_q <= stall_q + 1'b1;
            if (ifid_flush) flush_q <= flush_q + 16'd1;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.ifid_write   = ifid_write;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.pipe_freeze  = pipe_freeze;
    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LOAD_LAT=1 with a 4-bit stall counter, LOAD_LAT=3 with 32 bits)
// share one stimulus stream and are compared cycle by cycle against a bubble-budget reference model.
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] state_a, state_b;

    hazard_stall_ctrl_if #(.CNT_W(4))  hz_a ();
    hazard_stall_ctrl_if #(.CNT_W(32)) hz_b ();

    hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .hz(hz_a.slave), .state_o(state_a)
    );
    hazard_stall_ctrl #(.LOAD_LAT(3), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .hz(hz_b.slave), .state_o(state_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: bubbles still owed, and running stall/flush totals.
    int     lat[2]     = '{1, 3};
    int     left[2]    = '{0, 0};
    longint stalls[2]  = '{0, 0};
    longint flushes[2] = '{0, 0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}; advances the model one cycle.
    function automatic logic [4:0] model(input int k, input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                                         input bit u1, input bit u2, input logic [4:0] rd,
                                         input bit mr, input bit br, input bit busy);
        logic [4:0] c;
        bit lu;
        if (r) begin
            left[k] = 0; stalls[k] = 0; flushes[k] = 0;
            return 5'b11000;
        end
        lu = mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
        if (busy)           c = 5'b00001;
        else if (br)        begin c = 5'b11110; left[k] = 0; end
        else if (left[k] > 0) begin c = 5'b00010; left[k]--; end
        else if (lu)        begin c = 5'b00010; left[k] = lat[k] - 1; end
        else                c = 5'b11000;
        if (!c[4]) stalls[k]++;
        if (c[2])  flushes[k]++;
        return c;
    endfunction

    function automatic logic [4:0] ctrl_a();
        return {hz_a.pc_write, hz_a.ifid_write, hz_a.ifid_flush, hz_a.idex_bubble, hz_a.pipe_freeze};
    endfunction

    function automatic logic [4:0] ctrl_b();
        return {hz_b.pc_write, hz_b.ifid_write, hz_b.ifid_flush, hz_b.idex_bubble, hz_b.pipe_freeze};
    endfunction

    task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                        input logic [4:0] rd, input bit mr, input bit br, input bit busy);
        logic [4:0] ea, eb;
        @(negedge clk);
        rst = r;
        hz_a.id_rs1 = rs1; hz_a.id_rs2 = rs2; hz_a.id_use_rs1 = u1; hz_a.id_use_rs2 = u2;
        hz_a.idex_rd = rd; hz_a.idex_memread = mr; hz_a.ex_branch_tkn = br; hz_a.dmem_busy = busy;
        hz_b.id_rs1 = rs1; hz_b.id_rs2 = rs2; hz_b.id_use_rs1 = u1; hz_b.id_use_rs2 = u2;
        hz_b.idex_rd = rd; hz_b.idex_memread = mr; hz_b.ex_branch_tkn = br; hz_b.dmem_busy = busy;
        #1;
        chk("a_stall_cycles", 64'(hz_a.stall_cycles), 64'(stalls[0] % 16));
        chk("b_stall_cycles", 64'(hz_b.stall_cycles), 64'(stalls[1] % 64'h1_0000_0000));
        chk("a_flush_count",  64'(hz_a.flush_count),  64'(flushes[0] % 65536));
        chk("b_flush_count",  64'(hz_b.flush_count),  64'(flushes[1] % 65536));
        ea = model(0, r, rs1, rs2, u1, u2, rd, mr, br, busy);
        eb = model(1, r, rs1, rs2, u1, u2, rd, mr, br, busy);
        chk("a_ctrl", 64'(ctrl_a()), 64'(ea));
        chk("b_ctrl", 64'(ctrl_b()), 64'(eb));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        hz_a.id_rs1 = '0; hz_a.id_rs2 = '0; hz_a.id_use_rs1 = 0; hz_a.id_use_rs2 = 0;
        hz_a.idex_rd = '0; hz_a.idex_memread = 0; hz_a.ex_branch_tkn = 0; hz_a.dmem_busy = 0;
        hz_b.id_rs1 = '0; hz_b.id_rs2 = '0; hz_b.id_use_rs1 = 0; hz_b.id_use_rs2 = 0;
        hz_b.idex_rd = '0; hz_b.idex_memread = 0; hz_b.ex_branch_tkn = 0; hz_b.dmem_busy = 0;
        repeat (2) @(posedge clk);

        // T1: ld x5 then add x6,x5,x1
        do_reset();
        step(0, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0);
        idle(4);
        chk("t1_a_stalls", 64'(hz_a.stall_cycles), 64'd1);
        chk("t1_b_stalls", 64'(hz_b.stall_cycles), 64'd3);

        // T2: load into x0 never stalls
        do_reset();
        step(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0);
        step(0, 5'd0, 5'd3, 1, 0, 5'd0, 1, 0, 0);
        chk("t2_a_pc_write", 64'(hz_a.pc_write), 64'd1);
        idle(1);
        chk("t2_b_stalls", 64'(hz_b.stall_cycles), 64'd0);

        // T3: dmem_busy for 2 cycles inside the load stall
        do_reset();
        step(0, 5'd7, 5'd2, 0, 1, 5'd2, 1, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        idle(4);
        chk("t3_b_stalls", 64'(hz_b.stall_cycles), 64'd5);

        // T4: branch taken together with load-use
        do_reset();
        step(0, 5'd5, 5'd1, 1, 1, 5'd5, 1, 1, 0);
        idle(1);
        chk("t4_b_flushes", 64'(hz_b.flush_count), 64'd1);
        chk("t4_b_stalls",  64'(hz_b.stall_cycles), 64'd0);

        // T5: 4-cycle freeze in RUN, then 16 stall cycles wrap the 4-bit counter
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        idle(1);
        chk("t5_b_stalls", 64'(hz_b.stall_cycles), 64'd4);
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        idle(1);
        chk("t5_a_wrap", 64'(hz_a.stall_cycles), 64'd0);
        chk("t5_b_nowrap", 64'(hz_b.stall_cycles), 64'd16);

        // T6: reset on the second LD_STALL cycle
        do_reset();
        step(0, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0);
        idle(1);
        step(1, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0);
        idle(1);
        chk("t6_b_ctrl", 64'(ctrl_b()), 64'(5'b11000));
        chk("t6_b_stalls", 64'(hz_b.stall_cycles), 64'd0);

        // Randomized traffic over a small register window so hazards are frequent.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15);
        end
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
